i2s_to_axis: RTL and testbench

- I2S slave receiver: samples external SCLK/LRCLK/SDATA from an ADC or codec, entirely in the aud_mclk domain.
- Deserialises the left and right channel words and emits one AXI-Stream beat per channel word, with tid identifying the channel.
- Forms the capture path that mirrors the playback path. Output feeds a CDC FIFO toward the s_axis_aud_aclk domain.

---
 rtl/i2s_to_axis_if.sv | 26 ++
 rtl/i2s_to_axis.sv | 234 +++++++++++++++++++++++
 tb/tb_i2s_to_axis.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_to_axis_if.sv
// ---------------------------------------------------------------------------
// i2s_to_axis_if
//   AXI-Stream audio channel carried from the I2S receiver to its consumer.
//   Signals:
//     tdata  [31:0] sample, sign-extended
//     tid    [2:0]  channel number (0 = left, 1 = right)
//     tvalid        beat valid
//     tready        beat accepted by the consumer
//     tlast         right-channel beat marker (only with I2S_RX_TLAST_EN)
//   Modports: master (receiver side), slave (consumer side).
// ---------------------------------------------------------------------------
interface i2s_to_axis_if;
  logic [31:0] tdata;
  logic [2:0]  tid;
  logic        tvalid;
  logic        tready;
`ifdef I2S_RX_TLAST_EN
  logic        tlast;

  modport master (output tdata, output tid, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tid, input tvalid, input tlast, output tready);
`else
  modport master (output tdata, output tid, output tvalid, input tready);
  modport slave  (input tdata, input tid, input tvalid, output tready);
`endif
endinterface

// File: rtl/i2s_to_axis.sv
// ---------------------------------------------------------------------------
// i2s_to_axis
//   I2S slave receiver running entirely in the aud_mclk domain. The external
//   SCLK/LRCLK/SDATA pins are synchronised, SCLK rising edges are detected,
//   left/right words are deserialised MSB-first and each complete word is
//   written into a small first-word-fall-through FIFO that feeds an
//   AXI-Stream master (tid = channel).
//
//   Optional feature macro: I2S_RX_TLAST_EN
//     adds tlast on right-channel beats and drops any right word whose
//     preceding left word did not make it into the FIFO, keeping L/R pairs.
//
//   Ports:
//     aud_mclk        sole clock (>= 4x SCLK)
//     aud_mrst        synchronous active-high reset
//     sclk_in         I2S bit clock (asynchronous)
//     lrclk_in        word select, 0 = left, 1 = right (asynchronous)
//     sdata_in        serial data (asynchronous)
//     enable_i        receive enable
//     overflow_clr_i  pulse clearing overflow_o
//     m_axis_aud      AXI-Stream master (i2s_to_axis_if.master)
//     overflow_o      sticky: a word was dropped on a full FIFO
//     frame_err_o     one-cycle pulse: a short word was discarded
// ---------------------------------------------------------------------------
module i2s_to_axis #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int FIFO_LOG_DEPTH = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          aud_mclk,
  input  logic          aud_mrst,
  input  logic          sclk_in,
  input  logic          lrclk_in,
  input  logic          sdata_in,
  input  logic          enable_i,
  input  logic          overflow_clr_i,
  i2s_to_axis_if.master m_axis_aud,
  output logic          overflow_o,
  output logic          frame_err_o
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
  localparam int DEPTH = 1 << FIFO_LOG_DEPTH;
  localparam logic [CNT_W-1:0]          CNT_FULL  = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_LOG_DEPTH:0]   FIFO_FULL = (FIFO_LOG_DEPTH + 1)'(DEPTH);
  localparam logic [FIFO_LOG_DEPTH:0]   LVL_ONE   = (FIFO_LOG_DEPTH + 1)'(1);
  localparam logic [FIFO_LOG_DEPTH-1:0] PTR_ONE   = FIFO_LOG_DEPTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Sign-extend a captured word to the 32-bit stream width.
  function automatic logic [31:0] sext(input logic [SAMPLE_WIDTH-1:0] w);
    sext = 32'($signed(w));
  endfunction

  logic [SYNC_STAGES-1:0]    sclk_sync_r, lr_sync_r, sdata_sync_r;
  logic                      sclk_prev_r;
  logic                      lr_q_r;
  state_t                    state_r;
  logic [CNT_W-1:0]          bit_cnt_r;
  logic [SAMPLE_WIDTH-1:0]   shift_r;
  logic [SAMPLE_WIDTH-1:0]   mem_r [DEPTH];
  logic                      mem_ch_r [DEPTH];
  logic [FIFO_LOG_DEPTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_LOG_DEPTH:0]   count_r;
  logic                      overflow_r, frame_err_r;
`ifdef I2S_RX_TLAST_EN
  logic                      left_ok_r;
`endif

  logic                    sclk_s, lr_s, sdata_s, bit_stb_s, lr_change_s;
  logic [SAMPLE_WIDTH-1:0] word_s;
  logic [CNT_W-1:0]        cnt_next_s;
  logic                    word_done_s, word_full_s, pair_ok_s, push_req_s;
  logic                    valid_s, pop_s, full_s, push_s, ovf_evt_s, short_s;

  // Edge detect, word assembly and FIFO push/pop decisions.
  always_comb begin
    sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    lr_s        = lr_sync_r[SYNC_STAGES-1];
    sdata_s     = sdata_sync_r[SYNC_STAGES-1];
    bit_stb_s   = sclk_s & ~sclk_prev_r;
    lr_change_s = bit_stb_s & (lr_s != lr_q_r);
    // Bits past SAMPLE_WIDTH are ignored, which MSB-aligns long slots.
    if (bit_cnt_r < CNT_FULL) begin
      word_s     = {shift_r[SAMPLE_WIDTH-2:0], sdata_s};
      cnt_next_s = bit_cnt_r + CNT_ONE;
    end else begin
      word_s     = shift_r;
      cnt_next_s = bit_cnt_r;
    end
    word_done_s = (state_r == S_RUN) & enable_i & lr_change_s;
    word_full_s = (cnt_next_s == CNT_FULL);
`ifdef I2S_RX_TLAST_EN
    pair_ok_s   = ~lr_q_r | left_ok_r;
`else
    pair_ok_s   = 1'b1;
`endif
    push_req_s  = word_done_s & word_full_s & pair_ok_s;
    valid_s     = (count_r != '0);
    pop_s       = valid_s & m_axis_aud.tready;
    full_s      = (count_r == FIFO_FULL);
    // A pop in the same cycle frees the slot the push needs.
    push_s      = push_req_s & (~full_s | pop_s);
    ovf_evt_s   = push_req_s & full_s & ~pop_s;
    short_s     = word_done_s & ~word_full_s;
  end

  // Input synchronisers, SCLK edge history and previous LR sample.
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      sclk_sync_r  <= '0;
      lr_sync_r    <= '0;
      sdata_sync_r <= '0;
      sclk_prev_r  <= 1'b0;
      lr_q_r       <= 1'b0;
    end else begin
      sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_in};
      lr_sync_r    <= {lr_sync_r[SYNC_STAGES-2:0], lrclk_in};
      sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], sdata_in};
      sclk_prev_r  <= sclk_s;
      if (bit_stb_s) begin
        lr_q_r <= lr_s;
      end
    end
  end

  // Framing FSM with bit counter and shift register; enable loss wins.
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= '0;
      shift_r   <= '0;
`ifdef I2S_RX_TLAST_EN
      left_ok_r <= 1'b0;
`endif
    end else if (!enable_i) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= '0;
`ifdef I2S_RX_TLAST_EN
      left_ok_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r   <= S_SYNC;
          bit_cnt_r <= '0;
        end
        S_SYNC: begin
          if (lr_change_s) begin
            state_r   <= S_RUN;
            bit_cnt_r <= '0;
          end
        end
        S_RUN: begin
          if (lr_change_s) begin
            bit_cnt_r <= '0;
`ifdef I2S_RX_TLAST_EN
            // Only a left word that reached the FIFO licenses the next right.
            left_ok_r <= ~lr_q_r & push_s;
`endif
          end else if (bit_stb_s) begin
            bit_cnt_r <= cnt_next_s;
            shift_r   <= word_s;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          bit_cnt_r <= '0;
        end
      endcase
    end
  end

  // FIFO storage; contents are qualified by count_r so need no reset.
  always_ff @(posedge aud_mclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r]    <= word_s;
      mem_ch_r[wr_ptr_r] <= lr_q_r;
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LVL_ONE;
        2'b01:   count_r <= count_r - LVL_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Status flags: overflow set beats a same-cycle clear.
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end else if (overflow_clr_i) begin
        overflow_r <= 1'b0;
      end
      frame_err_r <= short_s;
    end
  end

  // Stream outputs read straight from FIFO registers, zero when empty.
  assign m_axis_aud.tvalid = valid_s;
  assign m_axis_aud.tdata  = valid_s ? sext(mem_r[rd_ptr_r]) : 32'h0000_0000;
  assign m_axis_aud.tid    = {2'b00, valid_s & mem_ch_r[rd_ptr_r]};
`ifdef I2S_RX_TLAST_EN
  assign m_axis_aud.tlast  = valid_s & mem_ch_r[rd_ptr_r];
`endif
  assign overflow_o        = overflow_r;
  assign frame_err_o       = frame_err_r;

endmodule

// File: tb/tb_i2s_to_axis.sv
// ---------------------------------------------------------------------------
// tb_i2s_to_axis
//   Self-checking bench for i2s_to_axis. I2S slots are described as
//   (channel, slot length, value) records; a reference model derives the
//   expected beats and frame-error count from those records. Build with
//   +define+I2S_RX_TLAST_EN to exercise the L/R pairing feature.
// ---------------------------------------------------------------------------
module tb_i2s_to_axis;
  localparam int SW = 16;
`ifdef I2S_RX_TLAST_EN
  localparam bit TLAST = 1'b1;
`else
  localparam bit TLAST = 1'b0;
`endif

  typedef struct {
    logic        ch;
    int          len;
    logic [31:0] val;
  } slot_t;

  logic aud_mclk = 1'b0;
  logic aud_mrst, sclk_in, lrclk_in, sdata_in, enable_i, overflow_clr_i;
  logic overflow_o, frame_err_o;
  logic mon_tl;

  i2s_to_axis_if m_axis_aud();

  i2s_to_axis #(.SAMPLE_WIDTH(SW), .FIFO_LOG_DEPTH(2), .SYNC_STAGES(2)) dut (
    .aud_mclk       (aud_mclk),
    .aud_mrst       (aud_mrst),
    .sclk_in        (sclk_in),
    .lrclk_in       (lrclk_in),
    .sdata_in       (sdata_in),
    .enable_i       (enable_i),
    .overflow_clr_i (overflow_clr_i),
    .m_axis_aud     (m_axis_aud),
    .overflow_o     (overflow_o),
    .frame_err_o    (frame_err_o)
  );

  always #5 aud_mclk = ~aud_mclk;

  int          checks = 0;
  int          errors = 0;
  int          ferr_cnt = 0;
  int          exp_ferr;
  slot_t       stream[$];
  logic [35:0] got[$];
  logic [35:0] exp[$];

  // Monitor: record accepted beats {tlast, tid, tdata} and frame errors.
  always @(negedge aud_mclk) begin
`ifdef I2S_RX_TLAST_EN
    mon_tl = m_axis_aud.tlast;
`else
    mon_tl = 1'b0;
`endif
    if (m_axis_aud.tvalid === 1'b1 && m_axis_aud.tready === 1'b1)
      got.push_back({mon_tl, m_axis_aud.tid, m_axis_aud.tdata});
    if (frame_err_o === 1'b1) ferr_cnt++;
  end

  // One SCLK period (8 mclk): data and LR change while SCLK is low.
  task automatic send_bit(input logic lr, input logic d);
    @(negedge aud_mclk);
    lrclk_in = lr; sdata_in = d; sclk_in = 1'b0;
    repeat (4) @(negedge aud_mclk);
    sclk_in = 1'b1;
    repeat (3) @(negedge aud_mclk);
  endtask

  // Disable, park LR high, re-enable, then give the LR edge to left.
  task automatic resync();
    enable_i = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    enable_i = 1'b1;
    repeat (3) @(negedge aud_mclk);
    send_bit(1'b0, 1'b0);
  endtask

  // Standard I2S: the last bit of each slot goes out with the next channel's LR.
  task automatic send_stream();
    foreach (stream[k]) begin
      for (int j = 0; j < stream[k].len; j++)
        send_bit((j == stream[k].len - 1) ? ~stream[k].ch : stream[k].ch,
                 stream[k].val[stream[k].len - 1 - j]);
    end
    repeat (24) @(negedge aud_mclk);
  endtask

  // Reference model: cap is how many beats fit without any draining.
  task automatic model(input int cap);
    bit                 left_ok;
    logic        [31:0] w;
    logic signed [31:0] t;
    left_ok = 1'b0;
    exp.delete();
    exp_ferr = 0;
    foreach (stream[k]) begin
      if (stream[k].len < SW) begin
        exp_ferr++;
        left_ok = 1'b0;
      end else if (TLAST && stream[k].ch && !left_ok) begin
        left_ok = 1'b0;
      end else if (exp.size() >= cap) begin
        left_ok = 1'b0;
      end else begin
        w = stream[k].val >> (stream[k].len - SW);
        t = w << (32 - SW);
        t = t >>> (32 - SW);
        exp.push_back({TLAST & stream[k].ch, 2'b00, stream[k].ch, t});
        left_ok = !stream[k].ch;
      end
    end
  endtask

  task automatic add_slot(input logic ch, input int len, input logic [31:0] val);
    slot_t s;
    s.ch = ch; s.len = len; s.val = val;
    stream.push_back(s);
  endtask

  task automatic test_reset();
    aud_mrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aud_mclk);
      sclk_in = 1'($urandom); lrclk_in = 1'($urandom); sdata_in = 1'($urandom);
      enable_i = 1'($urandom); overflow_clr_i = 1'($urandom);
      m_axis_aud.tready = 1'($urandom);
    end
    checks++; if (m_axis_aud.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_aud.tvalid); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err_o); end
    sclk_in = 1'b0; lrclk_in = 1'b0; sdata_in = 1'b0; enable_i = 1'b0;
    overflow_clr_i = 1'b0; m_axis_aud.tready = 1'b1;
    @(negedge aud_mclk);
    aud_mrst = 1'b0;
    got.delete(); ferr_cnt = 0;
    enable_i = 1'b1;
    // Two frames of bits with LR never changing: the receiver stays in sync search.
    for (int i = 0; i < 64; i++) send_bit(1'b0, 1'($urandom));
    repeat (24) @(negedge aud_mclk);
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL sync_no_beats got %0d want 0", got.size()); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL sync_no_ferr got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_16bit();
    stream.delete(); got.delete(); ferr_cnt = 0;
    add_slot(1'b0, 16, 32'h1234);
    add_slot(1'b1, 16, 32'h8001);
    model(1000);
    resync();
    send_stream();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL b16_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL b16_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    if (got.size() > 1) begin
      checks++; if (got[1][31:0] !== 32'hFFFF_8001) begin errors++; $display("FAIL b16_signext got %h want ffff8001", got[1][31:0]); end
    end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL b16_ferr got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_slot32();
    stream.delete(); got.delete(); ferr_cnt = 0;
    add_slot(1'b0, 32, 32'h7FFF_A5A5);
    add_slot(1'b1, 32, $urandom);
    model(1000);
    resync();
    send_stream();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL s32_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL s32_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    if (got.size() > 0) begin
      checks++; if (got[0][31:0] !== 32'h0000_7FFF) begin errors++; $display("FAIL s32_left got %h want 00007fff", got[0][31:0]); end
    end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL s32_ferr got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_random();
    int lens[3] = '{16, 24, 32};
    stream.delete(); got.delete(); ferr_cnt = 0;
    for (int i = 0; i < 8; i++)
      add_slot(1'(i % 2), lens[$urandom_range(0, 2)], $urandom);
    model(1000);
    resync();
    send_stream();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rnd_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL rnd_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
  endtask

  task automatic test_overflow();
    stream.delete(); got.delete(); ferr_cnt = 0;
    for (int i = 0; i < 6; i++) add_slot(1'(i % 2), 16, $urandom);
    model(4);
    m_axis_aud.tready = 1'b0;
    resync();
    send_stream();
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_o); end
    checks++; if ({m_axis_aud.tvalid, m_axis_aud.tdata} !== {1'b1, exp[0][31:0]})
      begin errors++; $display("FAIL ovf_hold got %b/%h want 1/%h", m_axis_aud.tvalid, m_axis_aud.tdata, exp[0][31:0]); end
    m_axis_aud.tready = 1'b1;
    repeat (10) @(negedge aud_mclk);
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL ovf_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
    overflow_clr_i = 1'b1;
    @(negedge aud_mclk);
    overflow_clr_i = 1'b0;
    @(negedge aud_mclk);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow_o); end
  endtask

  task automatic test_short_word();
    stream.delete(); got.delete(); ferr_cnt = 0;
    add_slot(1'b0, 12, $urandom);
    add_slot(1'b1, 16, $urandom);
    model(1000);
    resync();
    send_stream();
    checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL short_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL short_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL short_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_enable_midword();
    stream.delete(); got.delete(); ferr_cnt = 0;
    resync();
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'($urandom));
    add_slot(1'b0, 16, $urandom);
    add_slot(1'b1, 16, $urandom);
    model(1000);
    resync();
    send_stream();
    checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL enmid_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL enmid_beat%0d got %h want %h", i, got[i], exp[i]); end
    end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL enmid_ferr got %0d want 0", ferr_cnt); end
  endtask

  initial begin
    aud_mrst = 1'b1; sclk_in = 1'b0; lrclk_in = 1'b0; sdata_in = 1'b0;
    enable_i = 1'b0; overflow_clr_i = 1'b0; m_axis_aud.tready = 1'b1;
    test_reset();
    test_16bit();
    test_slot32();
    test_random();
    test_overflow();
    test_short_word();
    test_enable_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
